// File: rtl/pet_key_sched.sv
// pet_key_sched: merges PS/2 key events and timed UART "typed" keys into an
// 80-key PET keyboard matrix and serves it to the PIA row scan as an
// active-low column image.
// Optional feature: define PET_KEY_AUTOSHIFT_EN so that UART keys flagged with
// uart_shift also hold left SHIFT for the same window.
module pet_key_sched #(
  parameter int         TICK_DIV  = 50000,
  parameter int         HOLD_MS   = 40,
  parameter int         GAP_MS    = 20,
  parameter logic [6:0] SHIFT_IDX = 7'd64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_valid,
  input  logic [6:0] ps2_code,
  input  logic       ps2_release,
  output logic       ps2_ready,
  input  logic       uart_valid,
  input  logic [6:0] uart_code,
  input  logic       uart_shift,
  output logic       uart_ready,
  input  logic [3:0] keyrow,
  output logic [7:0] keycol_n,
  output logic       busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [6:0] NUM_KEYS = 7'd80;

  typedef enum logic [1:0] {IDLE, UART_HOLD, UART_GAP} state_t;

  state_t        state;
  logic [79:0]   matrix;
  logic [PW-1:0] presc;
  logic          tick;
  logic [15:0]   cnt;
  logic          prefer_uart;
  logic [6:0]    uart_key;
  logic          grant_uart;
  logic          ps2_fire;
  logic          uart_fire;
  logic          hold_end;
  logic [7:0]    row_bits;

`ifdef PET_KEY_AUTOSHIFT_EN
  logic          shift_owned;    // current UART key also asserted SHIFT
  logic          ps2_shift_down; // PS/2 is physically holding SHIFT
`else
  logic          unused_shift;
  assign unused_shift = uart_shift;
`endif

  // Arbitration: UART only wins in IDLE, and only when it is alone or it is its turn.
  // Reset gating keeps the handshake quiet while reset_n is low.
  assign grant_uart = reset_n && (state == IDLE) && uart_valid && (!ps2_valid || prefer_uart);
  assign uart_ready = grant_uart;
  assign ps2_ready  = !grant_uart;
  assign ps2_fire   = ps2_valid && ps2_ready;
  assign uart_fire  = uart_valid && uart_ready;
  assign tick       = (presc == PW'(TICK_DIV - 1));
  assign hold_end   = (state == UART_HOLD) && tick && (cnt <= 16'd1);

  // Free-running 1 ms prescaler.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // Sequencer FSM: grant rotation, hold/gap countdown and registered busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      prefer_uart <= 1'b0;
      uart_key    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Rotate only when both sources compete.
          if (ps2_valid && uart_valid) prefer_uart <= !grant_uart;
          if (uart_fire) begin
            uart_key <= uart_code;
            cnt      <= 16'(HOLD_MS);
            state    <= UART_HOLD;
            busy     <= 1'b1;
          end
        end
        UART_HOLD: begin
          if (tick) begin
            if (cnt <= 16'd1) begin
              cnt   <= 16'(GAP_MS);
              state <= UART_GAP;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
        end
        UART_GAP: begin
          if (tick) begin
            if (cnt <= 16'd1) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Key matrix: UART set/clear first, PS/2 last so it wins on a shared bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      matrix <= '0;
`ifdef PET_KEY_AUTOSHIFT_EN
      shift_owned    <= 1'b0;
      ps2_shift_down <= 1'b0;
`endif
    end else begin
      if (uart_fire && (uart_code < NUM_KEYS)) begin
        matrix[uart_code] <= 1'b1;
`ifdef PET_KEY_AUTOSHIFT_EN
        shift_owned <= uart_shift;
        if (uart_shift) matrix[SHIFT_IDX] <= 1'b1;
`endif
      end
      if (hold_end) begin
        if (uart_key < NUM_KEYS) matrix[uart_key] <= 1'b0;
`ifdef PET_KEY_AUTOSHIFT_EN
        if (shift_owned && !ps2_shift_down) matrix[SHIFT_IDX] <= 1'b0;
        shift_owned <= 1'b0;
`endif
      end
      if (ps2_fire && (ps2_code < NUM_KEYS)) begin
        matrix[ps2_code] <= !ps2_release;
`ifdef PET_KEY_AUTOSHIFT_EN
        if (ps2_code == SHIFT_IDX) ps2_shift_down <= !ps2_release;
`endif
      end
    end
  end

  // Column image of the selected row; rows 10..15 do not exist.
  always_comb begin
    // NOTE: default assignment first so no path leaves row_bits unassigned
    // (which would infer a latch).
    row_bits = 8'hFF;
    if (keyrow < 4'd10) row_bits = ~matrix[{keyrow, 3'b000} +: 8];
  end

  // Registered column output, one cycle behind keyrow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) keycol_n <= 8'hFF;
    else          keycol_n <= row_bits;
  end

endmodule

// File: tb/tb_pet_key_sched.sv
// Self-checking bench for pet_key_sched with a fast tick (TICK_DIV=4,
// HOLD_MS=3, GAP_MS=2). A key-array model tracks which keys should be down.
module tb_pet_key_sched;

  localparam int TICK_DIV = 4;
  localparam int HOLD_MS  = 3;
  localparam int GAP_MS   = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ps2_valid, ps2_release, ps2_ready;
  logic [6:0] ps2_code;
  logic       uart_valid, uart_shift, uart_ready;
  logic [6:0] uart_code;
  logic [3:0] keyrow;
  logic [7:0] keycol_n;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit model [0:79];

  pet_key_sched #(
    .TICK_DIV (TICK_DIV),
    .HOLD_MS  (HOLD_MS),
    .GAP_MS   (GAP_MS),
    .SHIFT_IDX(7'd64)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_valid  (ps2_valid),
    .ps2_code   (ps2_code),
    .ps2_release(ps2_release),
    .ps2_ready  (ps2_ready),
    .uart_valid (uart_valid),
    .uart_code  (uart_code),
    .uart_shift (uart_shift),
    .uart_ready (uart_ready),
    .keyrow     (keyrow),
    .keycol_n   (keycol_n),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_row(input int r);
    logic [7:0] b;
    b = 8'hFF;
    if (r < 10) for (int c = 0; c < 8; c++) b[c] = ~model[r * 8 + c];
    return b;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 80; i++) model[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    ps2_valid = 0; uart_valid = 0; uart_shift = 0;
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    clear_model();
  endtask

  task automatic check_row(input int r, input string tag);
    @(negedge clk);
    keyrow = 4'(r);
    @(negedge clk);
    checks++;
    if (keycol_n !== model_row(r)) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", tag, r, keycol_n, model_row(r));
    end
  endtask

  task automatic scan_all(input string tag);
    for (int r = 0; r < 16; r++) check_row(r, tag);
  endtask

  task automatic ps2_event(input logic [6:0] code, input bit rel);
    @(negedge clk);
    ps2_valid = 1; ps2_code = code; ps2_release = rel;
    #1;
    checks++;
    if (ps2_ready !== 1'b1) begin
      errors++;
      $display("FAIL ps2_ready code %0d: got %b expected 1", code, ps2_ready);
    end
    @(negedge clk);
    ps2_valid = 0;
    if (code < 80) model[code] = !rel;
  endtask

  task automatic uart_start(input logic [6:0] code, input bit shift);
    @(negedge clk);
    uart_valid = 1; uart_code = code; uart_shift = shift;
    #1;
    checks++;
    if (uart_ready !== 1'b1) begin
      errors++;
      $display("FAIL uart_ready idle code %0d: got %b expected 1", code, uart_ready);
    end
    @(negedge clk);
    uart_valid = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle timeout: busy %b expected 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 0; ps2_valid = 0; uart_valid = 1; uart_code = 7'd1; uart_shift = 0;
    ps2_code = 0; ps2_release = 0; keyrow = 4'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (keycol_n !== 8'hFF || busy !== 1'b0 || ps2_ready !== 1'b1 || uart_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: col %h busy %b ps2r %b uartr %b expected FF 0 1 0",
               keycol_n, busy, ps2_ready, uart_ready);
    end
    uart_valid = 0;
    reset_n = 1;
    clear_model();
    scan_all("post_reset");
  endtask

  task automatic test_ps2_basic();
    ps2_event(7'd17, 0);
    check_row(2, "ps2_press17");
    checks++;
    if (keycol_n !== 8'hFD) begin
      errors++;
      $display("FAIL press17 literal: got %h expected FD", keycol_n);
    end
    ps2_event(7'd17, 1);
    check_row(2, "ps2_release17");
  endtask

  task automatic test_ps2_random();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 40; i++)
        ps2_event(7'($urandom_range(0, 89)), bit'($urandom_range(0, 1)));
      // Deliberate repeats: double press and release of a not-held key.
      ps2_event(7'd33, 0); ps2_event(7'd33, 0);
      ps2_event(7'd34, 1); ps2_event(7'd34, 1);
      scan_all("ps2_random");
    end
  endtask

  task automatic test_out_of_range();
    ps2_event(7'd90, 0);
    check_row(15, "code90_row15");
    scan_all("code90_all");
  endtask

  task automatic test_uart_timing();
    int key_cycles, busy_cycles, ready_bad;
    bit done;
    do_reset();
    keyrow = 4'd1;
    @(negedge clk);
    uart_valid = 1; uart_code = 7'd9; uart_shift = 0;
    #1;
    checks++;
    if (uart_ready !== 1'b1) begin
      errors++;
      $display("FAIL uart_timing accept: ready %b expected 1", uart_ready);
    end
    key_cycles = 0; busy_cycles = 0; ready_bad = 0; done = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        busy_cycles++;
        if (uart_ready !== 1'b0) ready_bad++;
      end else begin
        done = 1;
        uart_valid = 0;
      end
      if (keycol_n[1] === 1'b0) key_cycles++;
    end
    uart_valid = 0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL uart_timing timeout: busy %b expected 0", busy);
    end
    checks++;
    if (key_cycles < HOLD_MS * TICK_DIV - TICK_DIV + 1 || key_cycles > HOLD_MS * TICK_DIV) begin
      errors++;
      $display("FAIL uart_hold_len: got %0d expected 9..12", key_cycles);
    end
    checks++;
    if (busy_cycles - key_cycles != GAP_MS * TICK_DIV) begin
      errors++;
      $display("FAIL uart_gap_len: got %0d expected %0d", busy_cycles - key_cycles, GAP_MS * TICK_DIV);
    end
    checks++;
    if (ready_bad != 0) begin
      errors++;
      $display("FAIL uart_ready_busy: got %0d high cycles expected 0", ready_bad);
    end
    scan_all("uart_after");
  endtask

  task automatic test_arbitration();
    int  grants;
    bit  exp_uart;
    do_reset();
    grants = 0; exp_uart = 0;
    @(negedge clk);
    ps2_valid = 1; ps2_code = 7'd5; ps2_release = 0;
    uart_valid = 1; uart_code = 7'd6; uart_shift = 0;
    for (int n = 0; n < 200 && grants < 3; n++) begin
      #1;
      checks++;
      if (busy === 1'b0) begin
        if (uart_ready !== exp_uart || ps2_ready !== !exp_uart) begin
          errors++;
          $display("FAIL grant %0d: uartr %b ps2r %b expected uartr %b", grants, uart_ready,
                   ps2_ready, exp_uart);
        end
        exp_uart = !exp_uart;
        grants++;
      end else if (uart_ready !== 1'b0 || ps2_ready !== 1'b1) begin
        errors++;
        $display("FAIL busy_ready: uartr %b ps2r %b expected 0 1", uart_ready, ps2_ready);
      end
      if (grants == 3) begin
        ps2_valid = 0; uart_valid = 0;
      end
      @(negedge clk);
    end
    ps2_valid = 0; uart_valid = 0;
    checks++;
    if (grants != 3) begin
      errors++;
      $display("FAIL grant_count: got %0d expected 3", grants);
    end
    model[5] = 1'b1;
    wait_idle("arb");
    scan_all("arb_after");
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    keyrow = 4'd1;
    uart_start(7'd9, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (keycol_n !== 8'hFD || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_hold: col %h busy %b expected FD 1", keycol_n, busy);
    end
    #2;
    uart_valid = 1; uart_code = 7'd9;
    reset_n = 0;
    #1;
    checks++;
    if (keycol_n !== 8'hFF || busy !== 1'b0 || ps2_ready !== 1'b1 || uart_ready !== 1'b0) begin
      errors++;
      $display("FAIL in_reset: col %h busy %b ps2r %b uartr %b expected FF 0 1 0",
               keycol_n, busy, ps2_ready, uart_ready);
    end
    @(negedge clk);
    uart_valid = 0;
    reset_n = 1;
    clear_model();
    @(negedge clk);
    checks++;
    if (keycol_n !== 8'hFF || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: col %h busy %b expected FF 0", keycol_n, busy);
    end
    uart_valid = 1; uart_code = 7'd85;
    #1;
    checks++;
    if (uart_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_idle: uartr %b expected 1", uart_ready);
    end
    uart_valid = 0;
    #1;
  endtask

  task automatic test_autoshift();
    do_reset();
    uart_start(7'd3, 1);
    model[3] = 1'b1;
`ifdef PET_KEY_AUTOSHIFT_EN
    model[64] = 1'b1;
`endif
    check_row(0, "autoshift_row0");
    check_row(8, "autoshift_row8");
    model[3] = 1'b0;
    model[64] = 1'b0;
    wait_idle("autoshift");
    check_row(0, "autoshift_row0_after");
    check_row(8, "autoshift_row8_after");
`ifdef PET_KEY_AUTOSHIFT_EN
    ps2_event(7'd64, 0);
    uart_start(7'd3, 1);
    wait_idle("autoshift_ps2");
    scan_all("autoshift_ps2_shift_kept");
    ps2_event(7'd64, 1);
`endif
  endtask

  task automatic test_random_uart();
    logic [6:0] code;
    bit         sh;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do code = 7'($urandom_range(0, 89)); while (code == 7'd64);
      sh = bit'($urandom_range(0, 1));
      uart_start(code, sh);
      if (code < 80) begin
        model[code] = 1'b1;
`ifdef PET_KEY_AUTOSHIFT_EN
        if (sh) model[64] = 1'b1;
`endif
      end
      check_row(int'(code) / 8, "uart_rand_hold");
      check_row(8, "uart_rand_shift");
      if (code < 80) model[code] = 1'b0;
      model[64] = 1'b0;
      wait_idle("uart_rand");
      check_row(int'(code) / 8, "uart_rand_after");
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_ps2_basic();
    test_ps2_random();
    test_out_of_range();
    test_uart_timing();
    test_arbitration();
    test_reset_mid_hold();
    test_autoshift();
    test_random_uart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pet_key_sched.md
PET_KEY_SCHED -- requirements
Module: pet_key_sched

Interface
REQ-001 Parameter TICK_DIV, default 50000: clk cycles per 1 ms tick.
REQ-002 Parameter HOLD_MS, default 40: UART key press hold time, in ticks.
REQ-003 Parameter GAP_MS, default 20: released gap after each UART key, in ticks.
REQ-004 Parameter SHIFT_IDX, default 7'd64: matrix index of left SHIFT key (row 8, column 0).
REQ-005 Port clk  in  1: single clock, rising-edge.
REQ-006 Port reset_n  in  1: asynchronous, active-low reset.
REQ-007 Port ps2_valid  in  1: PS/2 key event offered.
REQ-008 Port ps2_code  in  7: key index, row*8+col, 0..79.
REQ-009 Port ps2_release  in  1: 1 = release event, 0 = press event.
REQ-010 Port ps2_ready  out  1: PS/2 event accepted when valid&ready.
REQ-011 Port uart_valid  in  1: UART typed-key event offered.
REQ-012 Port uart_code  in  7: key index, 0..79.
REQ-013 Port uart_shift  in  1: key requires SHIFT (see Configuration).
REQ-014 Port uart_ready  out  1: UART event accepted when valid&ready.
REQ-015 Port keyrow  in  4: row selected by PIA scan.
REQ-016 Port keycol_n  out  8: active-low column image of selected row.
REQ-017 Port busy  out  1: high while a UART key sequence runs.

Function
REQ-018 Block SHALL hold an 80-bit key matrix; bit set = key down.
REQ-019 FSM states: IDLE, UART_HOLD, UART_GAP.
REQ-020 ps2_ready SHALL be 1 in all states, except 0 in IDLE on the cycle the round-robin grant goes to UART.
REQ-021 Accepted PS/2 event SHALL set (press) or clear (release) its matrix bit on the next clk edge.
REQ-022 uart_ready SHALL be 1 only in IDLE when UART holds the grant.
REQ-023 In IDLE with both valid, grant SHALL alternate, starting with PS/2 after reset; with one valid, that one SHALL be granted.
REQ-024 Accepted UART event SHALL set its matrix bit, load hold counter = HOLD_MS, and enter UART_HOLD.
REQ-025 In UART_HOLD, counter SHALL decrement once per tick; at 0, clear the UART key bit, load GAP_MS, and enter UART_GAP.
REQ-026 In UART_GAP, counter SHALL decrement per tick; at 0, enter IDLE.
REQ-027 Tick prescaler SHALL run freely, modulo TICK_DIV; the first hold period may be short by up to one tick.
REQ-028 busy SHALL be 1 in UART_HOLD and UART_GAP, else 0.
REQ-029 Codes >= 80 SHALL be accepted normally with no matrix effect; UART timing still runs.
REQ-030 Releasing a key that is not down, or pressing a key already down, SHALL leave the matrix unchanged.
REQ-031 PS/2 and UART writes to the same bit in one cycle: the PS/2 write SHALL win.
REQ-032 keycol_n SHALL be registered, one-cycle latency: bit c = ~matrix[keyrow*8+c] for keyrow 0..9, else 8'hFF.

Reset
REQ-033 reset_n low SHALL immediately clear the matrix, counters, prescaler and grant, and force IDLE.
REQ-034 During reset: keycol_n = 8'hFF, busy = 0, ps2_ready = 1, uart_ready = 0.
REQ-035 Reset during UART_HOLD SHALL drop the held key with no further release event needed.

Configuration
REQ-036 Macro PET_KEY_AUTOSHIFT_EN defined: an accepted UART event with uart_shift = 1 SHALL also set bit SHIFT_IDX for the same hold window; it SHALL be cleared with the key unless PS/2 holds SHIFT_IDX down.
REQ-037 Macro undefined: uart_shift SHALL be ignored, and the UART path SHALL never touch SHIFT_IDX.

Verification
REQ-038 PS/2 press code 17 -> after 2 edges, keyrow = 2 gives keycol_n = 8'hFD; release code 17 -> 8'hFF.
REQ-039 UART code 9, TICK_DIV = 4, HOLD_MS = 3, GAP_MS = 2 -> key down 9..12 cycles; busy high about 20 cycles; uart_ready low throughout.
REQ-040 PS/2 and UART valid together in IDLE, repeated -> grants alternate: PS/2, UART, PS/2.
REQ-041 reset_n pulsed low mid UART_HOLD -> keycol_n = 8'hFF on the next sample, busy = 0, state IDLE.
REQ-042 PET_KEY_AUTOSHIFT_EN defined, UART code 3 with shift -> rows 0 and 8 show 8'hF7 and 8'hFE during hold; with macro undefined, row 8 stays 8'hFF.
REQ-043 PS/2 code 90 press, keyrow = 15 -> keycol_n stays 8'hFF; ps2_ready stays 1.
